tnoc_axi_read_outstanding_limiter: RTL and testbench

TNOC_AXI_READ_OUTSTANDING_LIMITER -- requirements
Module: tnoc_axi_read_outstanding_limiter

---
 rtl/tnoc_axi_read_outstanding_limiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_tnoc_axi_read_outstanding_limiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnoc_axi_read_outstanding_limiter.sv
// AXI read outstanding limiter: 2-entry AR skid buffer, burst counter, R pass-through.
// Optional watchdog compiled in with TNOC_AXI_READ_TIMEOUT_EN.

package tnoc_axi_pkg;

    typedef struct packed {
        int unsigned id_width;
        int unsigned addr_width;
        int unsigned data_width;
    } tnoc_axi_config;

    localparam tnoc_axi_config TNOC_DEFAULT_CONFIG = '{
        id_width:   4,
        addr_width: 32,
        data_width: 32
    };

endpackage

interface tnoc_axi_read_if
    import tnoc_axi_pkg::*;
#(
    parameter tnoc_axi_config CONFIG = TNOC_DEFAULT_CONFIG
);
    localparam int IW = CONFIG.id_width;
    localparam int AW = CONFIG.addr_width;
    localparam int DW = CONFIG.data_width;

    logic          arvalid;
    logic          arready;
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;

    logic          rvalid;
    logic          rready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );

endinterface

module tnoc_axi_read_outstanding_limiter
    import tnoc_axi_pkg::*;
#(
    parameter tnoc_axi_config CONFIG          = TNOC_DEFAULT_CONFIG,
    parameter int             MAX_OUTSTANDING = 8,
    parameter int             TIMEOUT_CYCLES  = 1024,
    localparam int            CW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    tnoc_axi_read_if.slave  axi_in_if,
    tnoc_axi_read_if.master axi_out_if,
    output logic [CW-1:0]   o_outstanding,
    output logic            o_busy,
    output logic            o_underflow
`ifdef TNOC_AXI_READ_TIMEOUT_EN
    ,
    output logic            o_timeout
`endif
);

    localparam int            IW      = CONFIG.id_width;
    localparam int            AW      = CONFIG.addr_width;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
    } ar_t;

    ar_t           ent_q [2];
    ar_t           in_ar;
    ar_t           out_ar;
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    fill_q;
    logic [1:0]    fill_d;
    logic          in_ready_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          uf_q;
    logic          uf_d;
    logic          push;
    logic          pop;
    logic          out_valid;
    logic          last_hs;

    assign in_ar = '{
        id:    axi_in_if.arid,
        addr:  axi_in_if.araddr,
        len:   axi_in_if.arlen,
        size:  axi_in_if.arsize,
        burst: axi_in_if.arburst
    };

    assign push      = axi_in_if.arvalid && in_ready_q;
    assign out_valid = (fill_q != 2'd0) && (cnt_q < MAX_CNT);
    assign pop       = out_valid && axi_out_if.arready;
    assign last_hs   = axi_out_if.rvalid && axi_in_if.rready
                       && axi_out_if.rlast;

    // Next buffer occupancy from the input and output AR handshakes
    always_comb begin
        fill_d = fill_q;
        unique case ({push, pop})
            2'b10:   fill_d = fill_q + 2'd1;
            2'b01:   fill_d = fill_q - 2'd1;
            default: fill_d = fill_q;
        endcase
    end

    // Skid buffer storage, pointers and registered upstream ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q[0]   <= '0;
            ent_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fill_q     <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            if (push) begin
                ent_q[wr_ptr_q] <= in_ar;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            fill_q     <= fill_d;
            in_ready_q <= (fill_d != 2'd2);
        end
    end

    assign out_ar = ent_q[rd_ptr_q];

    // In-flight count update; an unmatched last beat flags underflow
    always_comb begin
        cnt_d = cnt_q;
        uf_d  = 1'b0;
        unique case (1'b1)
            (pop && !last_hs): begin
                cnt_d = cnt_q + CW'(1);
            end
            (last_hs && !pop): begin
                if (cnt_q == '0) begin
                    uf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Outstanding counter and underflow pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            uf_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            uf_q  <= uf_d;
        end
    end

    assign axi_in_if.arready  = in_ready_q;
    assign axi_out_if.arvalid = out_valid;
    assign axi_out_if.arid    = out_ar.id;
    assign axi_out_if.araddr  = out_ar.addr;
    assign axi_out_if.arlen   = out_ar.len;
    assign axi_out_if.arsize  = out_ar.size;
    assign axi_out_if.arburst = out_ar.burst;

    assign axi_in_if.rvalid   = axi_out_if.rvalid;
    assign axi_in_if.rid      = axi_out_if.rid;
    assign axi_in_if.rdata    = axi_out_if.rdata;
    assign axi_in_if.rresp    = axi_out_if.rresp;
    assign axi_in_if.rlast    = axi_out_if.rlast;
    assign axi_out_if.rready  = axi_in_if.rready;

    assign o_outstanding = cnt_q;
    assign o_busy        = (cnt_q != '0) || (fill_q != 2'd0);
    assign o_underflow   = uf_q;

`ifdef TNOC_AXI_READ_TIMEOUT_EN
    localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] wd_q;
    logic [TW-1:0] wd_d;
    logic          to_q;
    logic          r_hs;

    assign r_hs = axi_out_if.rvalid && axi_in_if.rready;

    // Watchdog counts idle cycles with bursts pending, saturating at the limit
    always_comb begin
        wd_d = wd_q;
        if ((cnt_q == '0) || r_hs) begin
            wd_d = '0;
        end else if (wd_q != TO_LIM) begin
            wd_d = wd_q + TW'(1);
        end
    end

    // Watchdog counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if (wd_d == TO_LIM) begin
                to_q <= 1'b1;
            end
        end
    end

    assign o_timeout = to_q;
`endif

endmodule

// File: tb/tb_tnoc_axi_read_outstanding_limiter.sv
// Bench for tnoc_axi_read_outstanding_limiter: directed steps plus random
// traffic, checked against a queue-based model of buffer and burst count.

module tb_tnoc_axi_read_outstanding_limiter;
    import tnoc_axi_pkg::*;

    localparam int MAXO = 2;
    localparam int CW   = $clog2(MAXO + 1);

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [CW-1:0] outst;
    logic          busy;
    logic          uf;
`ifdef TNOC_AXI_READ_TIMEOUT_EN
    logic          to;
`endif

    tnoc_axi_read_if in_if ();
    tnoc_axi_read_if out_if ();

    tnoc_axi_read_outstanding_limiter #(
        .MAX_OUTSTANDING(MAXO),
        .TIMEOUT_CYCLES (16)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .axi_in_if    (in_if),
        .axi_out_if   (out_if),
        .o_outstanding(outst),
        .o_busy       (busy),
        .o_underflow  (uf)
`ifdef TNOC_AXI_READ_TIMEOUT_EN
        ,
        .o_timeout    (to)
`endif
    );

    always #5 clk = ~clk;

    int  total = 0;
    int  bad = 0;
    ar_t mq[$];
    ar_t txq[$];
    int  m_out = 0;
    bit  m_rdy = 1'b0;
    bit  m_uf = 1'b0;
    bit  ar_en = 1'b1;

    task automatic chk(input string tag, input logic [63:0] o,
                       input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic ar_t rnd_ar();
        ar_t a;
        a.id    = 4'($urandom);
        a.addr  = $urandom;
        a.len   = 8'($urandom);
        a.size  = 3'($urandom);
        a.burst = 2'($urandom);
        return a;
    endfunction

    function automatic bit exp_valid();
        return (mq.size() > 0) && (m_out < MAXO);
    endfunction

    task automatic check_now();
        bit ev;
        ev = exp_valid();
        chk("in_arready", 64'(in_if.arready), 64'(m_rdy));
        chk("out_arvalid", 64'(out_if.arvalid), 64'(ev));
        if (ev) begin
            chk("ar_fields",
                64'({out_if.arid, out_if.araddr, out_if.arlen,
                     out_if.arsize, out_if.arburst}),
                64'(mq[0]));
        end
        chk("outstanding", 64'(outst), 64'(m_out));
        chk("busy", 64'(busy), 64'((m_out != 0) || (mq.size() != 0)));
        chk("underflow", 64'(uf), 64'(m_uf));
        chk("r_pass",
            64'({in_if.rvalid, in_if.rid, in_if.rdata, in_if.rresp,
                 in_if.rlast, out_if.rready}),
            64'({out_if.rvalid, out_if.rid, out_if.rdata, out_if.rresp,
                 out_if.rlast, in_if.rready}));
    endtask

    task automatic model_edge();
        bit fwd;
        bit acc;
        bit dec;
        if (!rst_n) begin
            mq.delete();
            m_out = 0;
            m_uf  = 1'b0;
            m_rdy = 1'b0;
            return;
        end
        fwd = exp_valid() && out_if.arready;
        acc = in_if.arvalid && m_rdy;
        dec = out_if.rvalid && in_if.rready && out_if.rlast;
        if (fwd) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(txq[0]);
            void'(txq.pop_front());
        end
        m_uf = 1'b0;
        if (fwd && !dec) begin
            m_out++;
        end else if (dec && !fwd) begin
            if (m_out == 0) m_uf = 1'b1;
            else m_out--;
        end
        m_rdy = (mq.size() < 2);
    endtask

    task automatic drive_ar();
        if (txq.size() > 0) begin
            in_if.arvalid = ar_en;
            {in_if.arid, in_if.araddr, in_if.arlen,
             in_if.arsize, in_if.arburst} = txq[0];
        end else begin
            in_if.arvalid = 1'b0;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_now();
        model_edge();
        @(posedge clk);
        #1;
        drive_ar();
    endtask

    task automatic r_idle();
        out_if.rvalid = 1'b0;
        out_if.rlast  = 1'b0;
        in_if.rready  = 1'b0;
    endtask

    task automatic rlast_pulse();
        out_if.rvalid = 1'b1;
        out_if.rlast  = 1'b1;
        in_if.rready  = 1'b1;
        out_if.rid    = 4'($urandom);
        out_if.rdata  = $urandom;
        cyc();
        r_idle();
    endtask

    task automatic drain();
        ar_en = 1'b1;
        out_if.arready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (mq.size() == 0 && m_out == 0 && txq.size() == 0) break;
            out_if.rvalid = (m_out != 0);
            out_if.rlast  = (m_out != 0);
            in_if.rready  = (m_out != 0);
            drive_ar();
            cyc();
        end
        r_idle();
        cyc();
        chk("drained_cnt", 64'(outst), 64'(0));
    endtask

    initial begin
        in_if.arvalid  = 1'b0;
        in_if.arid     = '0;
        in_if.araddr   = '0;
        in_if.arlen    = '0;
        in_if.arsize   = '0;
        in_if.arburst  = '0;
        in_if.rready   = 1'b0;
        out_if.arready = 1'b0;
        out_if.rvalid  = 1'b0;
        out_if.rid     = '0;
        out_if.rdata   = '0;
        out_if.rresp   = '0;
        out_if.rlast   = 1'b0;
        #2 rst_n = 1'b0;

        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("rdy_after_init", 64'(in_if.arready), 64'(1));

`ifdef TNOC_AXI_READ_TIMEOUT_EN
        out_if.arready = 1'b1;
        txq.push_back(rnd_ar());
        drive_ar();
        for (int k = 1; k <= 20; k++) begin
            cyc();
            chk("timeout", 64'(to), 64'(k >= 18));
        end
        drain();
`endif

        // back-to-back ARs against the limit
        out_if.arready = 1'b1;
        repeat (3) txq.push_back(rnd_ar());
        drive_ar();
        repeat (5) cyc();
        chk("lim_hold_valid", 64'(out_if.arvalid), 64'(0));
        chk("lim_cnt", 64'(outst), 64'(2));
        rlast_pulse();
        chk("lim_release", 64'(out_if.arvalid), 64'(1));
        cyc();
        chk("lim_cnt_again", 64'(outst), 64'(2));
        drain();

        // downstream stall with four ARs offered
        out_if.arready = 1'b0;
        repeat (4) txq.push_back(rnd_ar());
        drive_ar();
        repeat (5) cyc();
        chk("stall_rdy_low", 64'(in_if.arready), 64'(0));
        drain();

        // AR and last-beat handshakes in the same cycle at count 1
        out_if.arready = 1'b1;
        txq.push_back(rnd_ar());
        drive_ar();
        cyc();
        cyc();
        txq.push_back(rnd_ar());
        drive_ar();
        cyc();
        rlast_pulse();
        chk("same_cycle_cnt", 64'(outst), 64'(1));
        drain();

        // unmatched last beat at count 0
        rlast_pulse();
        chk("uf_pulse", 64'(uf), 64'(1));
        chk("uf_cnt", 64'(outst), 64'(0));
        cyc();
        chk("uf_clear", 64'(uf), 64'(0));

        // reset with buffered and in-flight bursts
        out_if.arready = 1'b1;
        repeat (2) txq.push_back(rnd_ar());
        drive_ar();
        repeat (4) cyc();
        out_if.arready = 1'b0;
        repeat (2) txq.push_back(rnd_ar());
        drive_ar();
        repeat (4) cyc();
        chk("pre_rst_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        txq.delete();
        model_edge();
        drive_ar();
        check_now();
        chk("rst_cnt", 64'(outst), 64'(0));
        chk("rst_arvalid", 64'(out_if.arvalid), 64'(0));
        chk("rst_arready", 64'(in_if.arready), 64'(0));
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("rdy_release", 64'(in_if.arready), 64'(1));

        // random traffic
        for (int n = 0; n < 500; n++) begin
            if (txq.size() < 3 && ($urandom % 2) == 0) txq.push_back(rnd_ar());
            ar_en          = ($urandom % 4) != 0;
            out_if.arready = ($urandom % 3) != 0;
            out_if.rvalid  = 1'($urandom);
            out_if.rlast   = ($urandom % 4) == 0;
            in_if.rready   = 1'($urandom);
            out_if.rid     = 4'($urandom);
            out_if.rdata   = $urandom;
            out_if.rresp   = 2'($urandom);
            drive_ar();
            cyc();
        end
        r_idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
